// File: rtl/uart_pkg.sv
// Shared state encoding and ASCII constants for the line assembler.
package uart_pkg;

  localparam int unsigned ASCII_W = 8;
  localparam logic [ASCII_W-1:0] CR = 8'h0D;
  localparam logic [ASCII_W-1:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2,
    ST_DISCARD = 2'd3
  } line_state_e;

endpackage

// File: rtl/line_buffer_ram.sv
// DEPTH x BUS_WIDTH buffer: one synchronous write port, one registered 1-cycle read port.
module line_buffer_ram #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [BUS_WIDTH-1:0]       i_wr_data,
  input  logic                       i_rd_en,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [BUS_WIDTH-1:0]       o_rd_data
);

  logic [BUS_WIDTH-1:0] r_mem [DEPTH];
  logic [BUS_WIDTH-1:0] r_rd_data;

  // Storage array is deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Only the read register is reset so the popped-byte output starts at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset)      r_rd_data <= BUS_WIDTH'(0);
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/line_assembler.sv
// Assembles received bytes into terminator-delimited lines and drains them byte by byte.
// Optional idle-gap line closing is enabled by defining LINE_TIMEOUT_EN.
module line_assembler
  import uart_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH      = 8,
  parameter int unsigned          DEPTH          = 16,
  parameter logic [BUS_WIDTH-1:0] TERMINATOR     = BUS_WIDTH'(CR),
  parameter int unsigned          TIMEOUT_CYCLES = 1000
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [BUS_WIDTH-1:0]         i_data,
  input  logic                         i_data_valid,
  input  logic                         i_rd_en,
  input  logic                         i_clr_flags,
  output logic [BUS_WIDTH-1:0]         o_rd_data,
  output logic                         o_rd_valid,
  output logic                         o_line_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_line_len,
  output logic                         o_overflow,
  output logic                         o_dropped,
  output logic                         o_line_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("line_assembler: DEPTH must be a power of two >= 4 and TIMEOUT_CYCLES nonzero");
  end

  line_state_e          r_state;
  line_state_e          w_state_nxt;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_rd_valid;
  logic                 r_overflow;
  logic                 r_dropped;
  logic [BUS_WIDTH-1:0] w_ram_q;
  logic                 w_collecting;
  logic                 w_is_term;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_last_pop;
  logic                 w_ovf_set;
  logic                 w_drop_set;
  logic                 w_tmo_fire;
  logic                 w_line_timeout;

  assign w_collecting = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign w_is_term    = (i_data == TERMINATOR);
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_accept     = i_data_valid && w_collecting && !w_full;
  assign w_ovf_set    = i_data_valid && w_collecting && w_full;
  assign w_drop_set   = i_data_valid && (r_state == ST_READY);
  assign w_pop        = i_rd_en && (r_state == ST_READY);
  assign w_last_pop   = w_pop && (r_count == CW'(1));

`ifdef LINE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_line_timeout;

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle after the last accepted byte.
  assign w_tmo_fire = (r_state == ST_COLLECT) && !i_data_valid &&
                      (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || r_state != ST_COLLECT || w_accept) r_tmo_cnt <= TW'(0);
    else                                              r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)                     r_line_timeout <= 1'b0;
    else if (w_tmo_fire)             r_line_timeout <= 1'b1;
    else if (w_state_nxt != ST_READY) r_line_timeout <= 1'b0;
  end

  assign w_line_timeout = r_line_timeout;
`else
  assign w_tmo_fire     = 1'b0;
  assign w_line_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; a terminator that would be byte DEPTH+1 ends an oversize line.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_COLLECT: begin
        if (i_data_valid) begin
          if (w_full)         w_state_nxt = w_is_term ? ST_IDLE : ST_DISCARD;
          else if (w_is_term) w_state_nxt = ST_READY;
          else                w_state_nxt = ST_COLLECT;
        end else if (w_tmo_fire) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY:   if (w_last_pop) w_state_nxt = ST_IDLE;
      ST_DISCARD: if (i_data_valid && w_is_term) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Pointers and count; every return to IDLE rewinds them.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_state_nxt == ST_IDLE) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
      r_count  <= r_count + CW'(1);
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= r_count - CW'(1);
    end
  end

  // Read strobe and sticky flags; a set event beats a coincident clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_ovf_set)        r_overflow <= 1'b1;
      else if (i_clr_flags) r_overflow <= 1'b0;
      if (w_drop_set)       r_dropped  <= 1'b1;
      else if (i_clr_flags) r_dropped  <= 1'b0;
    end
  end

  line_buffer_ram #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_data),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  // Output decode from registered state.
  always_comb begin
    o_line_ready   = (r_state == ST_READY);
    o_line_len     = (r_state == ST_READY) ? r_count : CW'(0);
    o_rd_data      = w_ram_q;
    o_rd_valid     = r_rd_valid;
    o_overflow     = r_overflow;
    o_dropped      = r_dropped;
    o_line_timeout = w_line_timeout;
  end

endmodule

// File: tb/tb_line_assembler.sv
// Directed and random checks of line_assembler against a queue-based line model.
module tb_line_assembler;

  localparam int unsigned BW   = 8;
  localparam int unsigned DEP  = 16;
  localparam int unsigned TMO  = 20;
  localparam logic [7:0]  TERM = 8'h0D;
`ifdef LINE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic [BW-1:0] i_data = '0;
  logic          i_data_valid = 1'b0;
  logic          i_rd_en = 1'b0;
  logic          i_clr_flags = 1'b0;
  logic [BW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          o_line_ready;
  logic [4:0]    o_line_len;
  logic          o_overflow;
  logic          o_dropped;
  logic          o_line_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: bytes of the line being built, bytes of the held line, and flags.
  logic [7:0] q_acc[$];
  logic [7:0] q_line[$];
  bit         m_held, m_disc, m_ovf, m_drop, m_tmo, m_rd_valid;
  int         m_idle;
  logic [7:0] m_rd_data;

  always #5 clk = ~clk;

  line_assembler #(
    .BUS_WIDTH      (BW),
    .DEPTH          (DEP),
    .TERMINATOR     (TERM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_data_valid   (i_data_valid),
    .i_rd_en        (i_rd_en),
    .i_clr_flags    (i_clr_flags),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_line_ready   (o_line_ready),
    .o_line_len     (o_line_len),
    .o_overflow     (o_overflow),
    .o_dropped      (o_dropped),
    .o_line_timeout (o_line_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit v, input logic [7:0] d, input bit rd, input bit clr, input bit rst);
    bit ovf_set, drop_set;
    ovf_set    = 1'b0;
    drop_set   = 1'b0;
    m_rd_valid = 1'b0;
    if (rst) begin
      q_acc.delete(); q_line.delete();
      m_held = 0; m_disc = 0; m_ovf = 0; m_drop = 0; m_tmo = 0; m_idle = 0;
      m_rd_data = 8'h00;
      return;
    end
    if (m_held) begin
      if (v) drop_set = 1'b1;
      if (rd) begin
        m_rd_valid = 1'b1;
        m_rd_data  = q_line.pop_front();
        if (q_line.size() == 0) begin m_held = 0; m_tmo = 0; end
      end
    end else if (m_disc) begin
      if (v && d == TERM) m_disc = 0;
    end else if (v) begin
      m_idle = 0;
      if (q_acc.size() == DEP) begin
        ovf_set = 1'b1;
        q_acc.delete();
        if (d != TERM) m_disc = 1;
      end else begin
        q_acc.push_back(d);
        if (d == TERM) begin q_line = q_acc; q_acc.delete(); m_held = 1; end
      end
    end else if (TMO_EN && q_acc.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        q_line = q_acc; q_acc.delete(); m_held = 1; m_tmo = 1; m_idle = 0;
      end
    end
    if (ovf_set)  m_ovf = 1; else if (clr) m_ovf = 0;
    if (drop_set) m_drop = 1; else if (clr) m_drop = 0;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rd, input bit clr, input bit rst);
    i_data_valid = v; i_data = d; i_rd_en = rd; i_clr_flags = clr; i_reset = rst;
    @(posedge clk);
    model(v, d, rd, clr, rst);
    #1;
    chk("rd_valid", {31'd0, o_rd_valid}, {31'd0, m_rd_valid});
    chk("rd_data", {24'd0, o_rd_data}, {24'd0, m_rd_data});
    chk("line_ready", {31'd0, o_line_ready}, {31'd0, m_held});
    chk("line_len", {27'd0, o_line_len}, m_held ? q_line.size() : 0);
    chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
    chk("dropped", {31'd0, o_dropped}, {31'd0, m_drop});
    chk("line_timeout", {31'd0, o_line_timeout}, {31'd0, m_tmo});
    i_data_valid = 0; i_rd_en = 0; i_clr_flags = 0; i_reset = 0;
  endtask

  task automatic send(input logic [7:0] d); step(1, d, 0, 0, 0); endtask
  task automatic rd();                      step(0, 8'h00, 1, 0, 0); endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    // Reset: everything zero.
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("rst_ready", {31'd0, o_line_ready}, 0);
    chk("rst_len", {27'd0, o_line_len}, 0);
    chk("rst_rd_data", {24'd0, o_rd_data}, 0);

    // Basic "AB\r" line and drain.
    send(8'h41); send(8'h42);
    chk("ab_not_ready", {31'd0, o_line_ready}, 0);
    send(8'h0D);
    chk("ab_ready", {31'd0, o_line_ready}, 1);
    chk("ab_len", {27'd0, o_line_len}, 3);
    rd(); chk("ab_rd0", {24'd0, o_rd_data}, 32'h41); chk("ab_len2", {27'd0, o_line_len}, 2);
    rd(); chk("ab_rd1", {24'd0, o_rd_data}, 32'h42);
    rd(); chk("ab_rd2", {24'd0, o_rd_data}, 32'h0D); chk("ab_valid2", {31'd0, o_rd_valid}, 1);
    chk("ab_done", {31'd0, o_line_ready}, 0);

    // Read request outside READY is ignored.
    rd(); chk("rd_idle", {31'd0, o_rd_valid}, 0);

    // Full-depth line with terminator as the DEPTH-th byte.
    for (int k = 0; k < 15; k++) send(8'h55);
    send(8'h0D);
    chk("full_len", {27'd0, o_line_len}, 16);
    chk("full_ovf", {31'd0, o_overflow}, 0);
    for (int k = 0; k < 16; k++) rd();
    chk("full_done", {31'd0, o_line_ready}, 0);

    // Oversize line is discarded, then a normal line follows.
    for (int k = 0; k < 17; k++) send(8'h55);
    send(8'h0D);
    chk("ovf_set", {31'd0, o_overflow}, 1);
    chk("ovf_not_ready", {31'd0, o_line_ready}, 0);
    send(8'h58); send(8'h0D);
    chk("x_ready", {31'd0, o_line_ready}, 1);
    chk("x_len", {27'd0, o_line_len}, 2);

    // Byte while a line is held is dropped; clear removes the flag.
    send(8'h33);
    chk("drop_set", {31'd0, o_dropped}, 1);
    chk("drop_len", {27'd0, o_line_len}, 2);
    step(1, 8'h44, 0, 1, 0);
    chk("set_beats_clr", {31'd0, o_dropped}, 1);
    step(0, 8'h00, 0, 1, 0);
    chk("drop_clr", {31'd0, o_dropped}, 0);
    chk("ovf_clr", {31'd0, o_overflow}, 0);
    rd(); chk("x_rd0", {24'd0, o_rd_data}, 32'h58);
    // Byte arriving with the last pop is dropped.
    step(1, 8'h77, 1, 0, 0);
    chk("lastpop_valid", {31'd0, o_rd_valid}, 1);
    chk("lastpop_data", {24'd0, o_rd_data}, 32'h0D);
    chk("lastpop_drop", {31'd0, o_dropped}, 1);
    chk("lastpop_idle", {31'd0, o_line_ready}, 0);
    step(0, 8'h00, 0, 1, 0);

    // Reset mid-drain abandons the line.
    send(8'h61); send(8'h62); send(8'h0D);
    rd(); rd();
    step(0, 8'h00, 1, 0, 1);
    chk("mid_rst_valid", {31'd0, o_rd_valid}, 0);
    chk("mid_rst_ready", {31'd0, o_line_ready}, 0);
    chk("mid_rst_data", {24'd0, o_rd_data}, 0);
    idle(3);
    send(8'h5A); send(8'h0D);
    chk("post_rst_len", {27'd0, o_line_len}, 2);
    rd(); chk("post_rst_rd", {24'd0, o_rd_data}, 32'h5A);
    rd();

    // Idle-gap behaviour after a partial "HI".
    send(8'h48); send(8'h49);
    idle(19);
    chk("tmo_early", {31'd0, o_line_ready}, 0);
    idle(1);
    chk("tmo_ready", {31'd0, o_line_ready}, {31'd0, TMO_EN});
    chk("tmo_flag", {31'd0, o_line_timeout}, {31'd0, TMO_EN});
    chk("tmo_len", {27'd0, o_line_len}, TMO_EN ? 2 : 0);
    if (TMO_EN) begin
      rd(); rd();
      chk("tmo_cleared", {31'd0, o_line_timeout}, 0);
    end else begin
      send(8'h0D); rd(); rd(); rd();
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      bit v, r, c, s;
      logic [7:0] d;
      v = ($urandom_range(0, 99) < 35);
      r = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 99) < 5);
      s = ($urandom_range(0, 199) == 0);
      d = ($urandom_range(0, 4) == 0) ? TERM : 8'($urandom_range(32, 126));
      step(v, d, r, c, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
